csa_add5_32: RTL and testbench

CSA_ADD5_32 -- requirements
Module: csa_add5_32

---
 rtl/csa_add5_32.sv | 127 ++++++++++++
 tb/tb_csa_add5_32.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_add5_32.sv
// Two-stage five-operand 32-bit adder: a carry-save reduction tree in stage 1,
// a carry-propagate add in stage 2, with valid/ready flow control on both ends.
module csa_add5_32 #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op0,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  input  logic [31:0]      in_op3,
  input  logic [31:0]      in_op4,
  input  logic [4:0]       in_en,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic [31:0]      op_m [5];

  logic [31:0]      a_sum, a_car;
  logic [31:0]      b_sum, b_car;
  logic [31:0]      c_sum, c_car;

  logic             adv1, adv2, in_xfer;

  logic             s1_valid_d, s1_valid_q;
  logic [31:0]      s1_sum_d,   s1_sum_q;
  logic [31:0]      s1_car_d,   s1_car_q;
  logic [TAG_W-1:0] s1_tag_d,   s1_tag_q;

  logic             s2_valid_d, s2_valid_q;
  logic [31:0]      s2_sum_d,   s2_sum_q;
  logic [TAG_W-1:0] s2_tag_d,   s2_tag_q;

  // A disabled operand enters the tree as zero; it still occupies its slot.
  always_comb begin
    op_m[0] = in_en[0] ? in_op0 : 32'd0;
    op_m[1] = in_en[1] ? in_op1 : 32'd0;
    op_m[2] = in_en[2] ? in_op2 : 32'd0;
    op_m[3] = in_en[3] ? in_op3 : 32'd0;
    op_m[4] = in_en[4] ? in_op4 : 32'd0;
  end

  // Three cascaded 3:2 levels; each carry vector is pre-shifted, dropping bit 31.
  always_comb begin
    a_sum = op_m[0] ^ op_m[1] ^ op_m[2];
    a_car = {((op_m[0][30:0] & op_m[1][30:0]) |
              (op_m[0][30:0] & op_m[2][30:0]) |
              (op_m[1][30:0] & op_m[2][30:0])), 1'b0};

    b_sum = a_sum ^ a_car ^ op_m[3];
    b_car = {((a_sum[30:0] & a_car[30:0]) |
              (a_sum[30:0] & op_m[3][30:0]) |
              (a_car[30:0] & op_m[3][30:0])), 1'b0};

    c_sum = b_sum ^ b_car ^ op_m[4];
    c_car = {((b_sum[30:0] & b_car[30:0]) |
              (b_sum[30:0] & op_m[4][30:0]) |
              (b_car[30:0] & op_m[4][30:0])), 1'b0};
  end

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1 && !reset;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_car_d   = s1_car_q;
    s1_tag_d   = s1_tag_q;
    if (adv1) begin
      s1_valid_d = in_xfer;
      if (in_xfer) begin
        s1_sum_d = c_sum;
        s1_car_d = c_car;
        s1_tag_d = in_tag;
      end
    end
  end

  // Stage 2 only reloads data when stage 1 has something to hand over.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_tag_d   = s2_tag_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_d = s1_sum_q + s1_car_q;
        s2_tag_d = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_car_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_car_q   <= s1_car_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_csa_add5_32.sv
// Directed and randomized checks of csa_add5_32 against hand-computed sums
// and a plain mod-2^32 reference model with an in-order scoreboard.
module tb_csa_add5_32;

  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_op0 = '0, in_op1 = '0, in_op2 = '0, in_op3 = '0, in_op4 = '0;
  logic [4:0]       in_en = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_sum;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  csa_add5_32 #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op0(in_op0), .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3), .in_op4(in_op4),
    .in_en(in_en), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, b, c, d, e, input logic [4:0] en,
                       input logic [TAG_W-1:0] tg);
    in_op0 = a; in_op1 = b; in_op2 = c; in_op3 = d; in_op4 = e;
    in_en = en; in_tag = tg; in_valid = 1'b1;
  endtask

  function automatic logic [31:0] ref_sum(input logic [31:0] a, b, c, d, e,
                                          input logic [4:0] en);
    logic [31:0] s;
    s = 32'd0;
    if (en[0]) s = s + a;
    if (en[1]) s = s + b;
    if (en[2]) s = s + c;
    if (en[3]) s = s + d;
    if (en[4]) s = s + e;
    return s;
  endfunction

  // Issues one op with out_ready high; reports result, tag and edges from accept to out_valid.
  task automatic run_op(input logic [31:0] a, b, c, d, e, input logic [4:0] en,
                        input logic [TAG_W-1:0] tg, output logic [31:0] sum,
                        output logic [TAG_W-1:0] rtag, output int lat);
    int w;
    out_ready = 1'b1;
    drive(a, b, c, d, e, en, tg);
    #1;
    w = 0;
    while (!in_ready && w < 10) begin step(); w++; end
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin step(); lat++; end
    sum = out_sum;
    rtag = out_tag;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (out_sum !== 32'd0 || out_tag !== '0) begin n_err++; $display("FAIL reset_data got=%h/%h exp=0/0", out_sum, out_tag); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    step(); step(); step();
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_op;
    logic [31:0] s; logic [TAG_W-1:0] t; int lat;
    run_op(1, 2, 3, 4, 5, 5'b11111, 8'h5A, s, t, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL single_latency got=%0d exp=2", lat); end
    n_cmp++; if (s !== 32'd15) begin n_err++; $display("FAIL single_sum got=%0d exp=15", s); end
    n_cmp++; if (t !== 8'h5A) begin n_err++; $display("FAIL single_tag got=%h exp=5a", t); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_one_cycle got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap;
    logic [31:0] s; logic [TAG_W-1:0] t; int lat;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
           5'b11111, 8'h11, s, t, lat);
    n_cmp++; if (s !== 32'hFFFFFFFB) begin n_err++; $display("FAIL wrap_all_ones got=%h exp=fffffffb", s); end
    run_op(32'h80000000, 32'h80000000, 32'h12345678, 32'h9, 32'h7, 5'b00011, 8'h22, s, t, lat);
    n_cmp++; if (s !== 32'd0) begin n_err++; $display("FAIL wrap_msb got=%h exp=0", s); end
    n_cmp++; if (t !== 8'h22) begin n_err++; $display("FAIL wrap_tag got=%h exp=22", t); end
  endtask

  task automatic test_masking;
    logic [31:0] s; logic [TAG_W-1:0] t; int lat;
    run_op(10, 20, 30, 40, 50, 5'b10101, 8'h33, s, t, lat);
    n_cmp++; if (s !== 32'd90) begin n_err++; $display("FAIL mask_10101 got=%0d exp=90", s); end
    run_op(10, 20, 30, 40, 50, 5'b00000, 8'hC3, s, t, lat);
    n_cmp++; if (s !== 32'd0) begin n_err++; $display("FAIL mask_none got=%0d exp=0", s); end
    n_cmp++; if (t !== 8'hC3 || lat !== 2) begin n_err++; $display("FAIL mask_none_slot got=tag %h lat %0d exp=tag c3 lat 2", t, lat); end
    run_op(10, 20, 30, 40, 50, 5'b01000, 8'h44, s, t, lat);
    n_cmp++; if (s !== 32'd40) begin n_err++; $display("FAIL mask_01000 got=%0d exp=40", s); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] c [4];
    logic [31:0] d [4];
    logic [31:0] e [4];
    logic [4:0]  en [4];
    logic [31:0] exp_s [4];
    a = '{1, 1, 32'h10, 32'hFFFFFFFF};
    b = '{2, 2, 32'h20, 32'hFFFFFFFF};
    c = '{3, 3, 32'h40, 32'hFFFFFFFF};
    d = '{4, 4, 32'h80, 32'hFFFFFFFF};
    e = '{5, 5, 32'h100, 32'hFFFFFFFF};
    en = '{5'b11111, 5'b01010, 5'b11100, 5'b10001};
    exp_s = '{32'd15, 32'd6, 32'h1C0, 32'hFFFFFFFE};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(a[i], b[i], c[i], d[i], e[i], en[i], 8'(8'h80 + i));
      else in_valid = 1'b0;
      step();
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== exp_s[i-1] || out_tag !== 8'(8'h80 + i - 1)) begin
          n_err++;
          $display("FAIL b2b_%0d got=v%b %h/%h exp=v1 %h/%h", i-1, out_valid, out_sum, out_tag,
                   exp_s[i-1], 8'(8'h80 + i - 1));
        end
      end
    end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=v%b busy%b exp=0/0", out_valid, busy); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(100, 200, 300, 400, 500, 5'b11111, 8'h01);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept0 got=%b exp=1", in_ready); end
    step();
    drive(7, 9, 9, 9, 9, 5'b00001, 8'h02);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept1 got=%b exp=1", in_ready); end
    step();
    drive(32'hFFFFFFFF, 2, 0, 0, 0, 5'b00011, 8'h03);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== 32'd1500 || out_tag !== 8'h01 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d got=v%b %0d/%h rdy%b exp=v1 1500/01 rdy0", k, out_valid, out_sum, out_tag, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 32'd7 || out_tag !== 8'h02) begin n_err++; $display("FAIL bp_out1 got=v%b %0d/%h exp=v1 7/02", out_valid, out_sum, out_tag); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 32'd1 || out_tag !== 8'h03) begin n_err++; $display("FAIL bp_out2 got=v%b %0d/%h exp=v1 1/03", out_valid, out_sum, out_tag); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_empty got=v%b busy%b exp=0/0", out_valid, busy); end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] s; logic [TAG_W-1:0] t; int lat;
    out_ready = 1'b0;
    drive(1, 1, 1, 1, 1, 5'b11111, 8'hA1);
    step();
    drive(2, 2, 2, 2, 2, 5'b11111, 8'hA2);
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL mid_full got=v%b busy%b exp=1/1", out_valid, busy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 32'd0) begin n_err++; $display("FAIL mid_clear got=v%b busy%b sum%h exp=0/0/0", out_valid, busy, out_sum); end
    step(); step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_%0d got=%b exp=0", k, out_valid); end
    end
    run_op(3, 4, 5, 6, 7, 5'b11111, 8'hA3, s, t, lat);
    n_cmp++; if (s !== 32'd25 || t !== 8'hA3) begin n_err++; $display("FAIL mid_next got=%0d/%h exp=25/a3", s, t); end
  endtask

  task automatic test_random;
    logic [31:0]      q_sum [$];
    logic [TAG_W-1:0] q_tag [$];
    logic [31:0]      es;
    logic [TAG_W-1:0] et;
    int               n_out;
    n_out = 0;
    for (int c = 0; c < 6010; c++) begin
      step();
      if (c < 6000) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_op0 = $urandom; in_op1 = $urandom; in_op2 = $urandom;
        in_op3 = $urandom; in_op4 = $urandom;
        in_en  = 5'($urandom_range(0, 31));
        in_tag = 8'($urandom_range(0, 255));
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q_sum.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra got=%h/%h exp=no output", out_sum, out_tag);
        end else begin
          es = q_sum.pop_front();
          et = q_tag.pop_front();
          n_out++;
          if (out_sum !== es || out_tag !== et) begin
            n_err++;
            $display("FAIL rand_%0d got=%h/%h exp=%h/%h", n_out, out_sum, out_tag, es, et);
          end
        end
      end
      if (in_valid && in_ready) begin
        q_sum.push_back(ref_sum(in_op0, in_op1, in_op2, in_op3, in_op4, in_en));
        q_tag.push_back(in_tag);
      end
    end
    n_cmp++; if (q_sum.size() != 0) begin n_err++; $display("FAIL rand_lost got=%0d exp=0 pending", q_sum.size()); end
    n_cmp++; if (n_out < 1000) begin n_err++; $display("FAIL rand_volume got=%0d exp=>=1000", n_out); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_wrap();
    test_masking();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
